vehicle_lane_scheduler: RTL

//  Sequences one vehicle lane of the traffic level. Holds the lane occupancy as a WIDTH-cell register and

---
 rtl/vehicle_lane_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vehicle_lane_scheduler.sv
// One vehicle lane: occupancy register stepped by a prescaled tick, with a spawn/wrap entry mux and frog hit flag.
// Define VEHLANE_LFSR_EN to draw spawn bits from an 8-bit LFSR instead of the rotating SPAWN_PATTERN.
module vehicle_lane_scheduler #(
    parameter int               WIDTH         = 8,
    parameter int               COL_W         = 3,
    parameter int               DIV_W         = 25,
    parameter int               SPEED_DIV     = 12_500_000,
    parameter logic [WIDTH-1:0] INIT_PATTERN  = 8'b1001_0010,
    parameter logic [WIDTH-1:0] SPAWN_PATTERN = 8'b1100_0000,
    parameter logic [7:0]       LFSR_SEED     = 8'hA5
) (
    input  logic             VEHLANE_CLOCK_50,
    input  logic             VEHLANE_RESET_InHigh,
    input  logic             VEHLANE_START_In,
    input  logic             VEHLANE_PAUSE_In,
    input  logic             VEHLANE_DIR_In,
    input  logic             VEHLANE_MODE_In,
    input  logic [COL_W-1:0] VEHLANE_FROG_COL_In,
    input  logic             VEHLANE_FROG_HERE_In,
    output logic [WIDTH-1:0] VEHLANE_LANE_Out,
    output logic             VEHLANE_STEP_Out,
    output logic             VEHLANE_HIT_Out,
    output logic [1:0]       VEHLANE_STATE_Out
);

    // state   | meaning
    // IDLE 00 | lane cleared, waiting for START
    // LOAD 01 | one cycle: load INIT_PATTERN, clear prescaler, reseed spawn source
    // RUN  10 | prescaler counts, lane shifts on terminal count
    // HOLD 11 | prescaler and lane frozen while PAUSE is high
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam int               PTR_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] LP_TC       = DIV_W'(SPEED_DIV - 1);
    localparam logic [PTR_W-1:0] LP_PTR_LAST = PTR_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_shift;
    logic               w_count;

    logic [WIDTH-1:0]   r_lane;
    logic [DIV_W-1:0]   r_presc;
    logic               r_step;
    logic               r_hit;

    logic               w_spawn;
    logic               w_wrap;
    logic               w_ins;
    logic [WIDTH-1:0]   w_lane_shift;
    logic               w_frog_bit;
    logic               w_hit_nxt;

    always_ff @(posedge VEHLANE_CLOCK_50 or posedge VEHLANE_RESET_InHigh) begin
        if (VEHLANE_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // START outranks PAUSE, which outranks the terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (VEHLANE_START_In) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = VEHLANE_START_In ? ST_LOAD : ST_RUN;
            end
            ST_RUN: begin
                if (VEHLANE_START_In) begin
                    w_state_nxt = ST_LOAD;
                end else if (VEHLANE_PAUSE_In) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_presc == LP_TC) begin
                    w_shift = 1'b1;
                end else begin
                    w_count = 1'b1;
                end
            end
            ST_HOLD: begin
                if (VEHLANE_START_In) begin
                    w_state_nxt = ST_LOAD;
                end else if (!VEHLANE_PAUSE_In) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef VEHLANE_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    // x^8 + x^6 + x^5 + x^4 + 1
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_spawn   = r_lfsr[0];

    always_ff @(posedge VEHLANE_CLOCK_50 or posedge VEHLANE_RESET_InHigh) begin
        if (VEHLANE_RESET_InHigh) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_load) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_shift) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end
`else
    logic [PTR_W-1:0] r_ptr;

    assign w_spawn = |(SPAWN_PATTERN & (WIDTH'(1) << r_ptr));

    always_ff @(posedge VEHLANE_CLOCK_50 or posedge VEHLANE_RESET_InHigh) begin
        if (VEHLANE_RESET_InHigh) begin
            r_ptr <= '0;
        end else if (w_load) begin
            r_ptr <= '0;
        end else if (w_shift) begin
            r_ptr <= (r_ptr == LP_PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end
`endif

    assign w_wrap       = VEHLANE_DIR_In ? r_lane[WIDTH-1] : r_lane[0];
    assign w_ins        = VEHLANE_MODE_In ? w_spawn : w_wrap;
    assign w_lane_shift = VEHLANE_DIR_In ? {r_lane[WIDTH-2:0], w_ins}
                                         : {w_ins, r_lane[WIDTH-1:1]};

    // A column beyond the lane shifts the probe bit out, so it never hits.
    assign w_frog_bit = |(r_lane & (WIDTH'(1) << VEHLANE_FROG_COL_In));
    assign w_hit_nxt  = ((r_state == ST_RUN) || (r_state == ST_HOLD))
                        && VEHLANE_FROG_HERE_In && w_frog_bit;

    always_ff @(posedge VEHLANE_CLOCK_50 or posedge VEHLANE_RESET_InHigh) begin
        if (VEHLANE_RESET_InHigh) begin
            r_lane  <= '0;
            r_presc <= '0;
            r_step  <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_step <= w_shift;
            r_hit  <= w_hit_nxt;
            if (r_state == ST_IDLE) begin
                r_lane <= '0;
            end else if (w_load) begin
                r_lane  <= INIT_PATTERN;
                r_presc <= '0;
            end else if (w_shift) begin
                r_lane  <= w_lane_shift;
                r_presc <= '0;
            end else if (w_count) begin
                r_presc <= r_presc + DIV_W'(1);
            end
        end
    end

    assign VEHLANE_LANE_Out  = r_lane;
    assign VEHLANE_STEP_Out  = r_step;
    assign VEHLANE_HIT_Out   = r_hit;
    assign VEHLANE_STATE_Out = r_state;

endmodule
